// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue sequencer: ALU opcodes, RV32 field constants,
// FSM state encoding and the decoder's output bundle.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_MUL = 3'b100,
    ALU_SLL = 3'b101,
    ALU_NOP = 3'b111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP2_RS2 = 1'b0,
    OP2_IMM = 1'b1
  } op2_sel_e;

  typedef struct packed {
    alu_op_e  alu_op;
    op2_sel_e op2_sel;
    logic     wb_en;
    logic     is_branch;
    logic     br_neg;
    logic     illegal;
  } dec_t;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational RV32 instruction decoder: maps the supported R/I/branch subset onto
// an ALU opcode, operand-2 source and immediate; everything else is flagged illegal.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_t            dec_c,
  output logic [XLEN-1:0] imm_c
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       unused_rs1_idx;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];
  assign rd  = instr[11:7];
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    dec_c = '{alu_op: ALU_NOP, op2_sel: OP2_RS2, wb_en: 1'b0,
              is_branch: 1'b0, br_neg: 1'b0, illegal: 1'b1};
    imm_c = {{(XLEN-12){instr[31]}}, instr[31:20]};

    case (opc)
      OPC_OP: begin
        case (f3)
          F3_ADD: begin
            if (f7 == F7_BASE) begin
              dec_c.alu_op = ALU_ADD; dec_c.illegal = 1'b0;
            end else if (f7 == F7_SUB) begin
              dec_c.alu_op = ALU_SUB; dec_c.illegal = 1'b0;
            end else if (f7 == F7_MUL) begin
              dec_c.alu_op = ALU_MUL; dec_c.illegal = 1'b0;
            end
          end
          F3_AND: if (f7 == F7_BASE) begin dec_c.alu_op = ALU_AND; dec_c.illegal = 1'b0; end
          F3_OR:  if (f7 == F7_BASE) begin dec_c.alu_op = ALU_OR;  dec_c.illegal = 1'b0; end
          F3_SLL: if (f7 == F7_BASE) begin dec_c.alu_op = ALU_SLL; dec_c.illegal = 1'b0; end
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        dec_c.op2_sel = OP2_IMM;
        case (f3)
          F3_ADD: begin dec_c.alu_op = ALU_ADD; dec_c.illegal = 1'b0; end
          F3_AND: begin dec_c.alu_op = ALU_AND; dec_c.illegal = 1'b0; end
          F3_OR:  begin dec_c.alu_op = ALU_OR;  dec_c.illegal = 1'b0; end
          F3_SLL: begin
            if (f7 == F7_BASE) begin
              dec_c.alu_op = ALU_SLL; dec_c.illegal = 1'b0;
              imm_c = XLEN'(instr[24:20]);
            end
          end
          default: ;
        endcase
      end
      OPC_BRANCH: begin
        // Branches compare via SUB and read the zero flag; BNE inverts the outcome.
        if (f3 == F3_BEQ || f3 == F3_BNE) begin
          dec_c.alu_op    = ALU_SUB;
          dec_c.is_branch = 1'b1;
          dec_c.br_neg    = (f3 == F3_BNE);
          dec_c.illegal   = 1'b0;
        end
      end
      default: ;
    endcase

    dec_c.wb_en = !dec_c.illegal && !dec_c.is_branch && (rd != 5'd0);
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue-side controller: accepts an instruction, drives the external ALU for one
// cycle, captures its result and presents a writeback/branch response.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RES_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  output logic [XLEN-1:0]  alu_operand1,
  output logic [XLEN-1:0]  alu_operand2,
  output logic [2:0]       alu_op,
  input  logic [RES_W-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_rd,
  output logic             out_wb_en,
  output logic             out_branch_taken,
  output logic             out_illegal
);

  dec_t            dec_c;
  logic [XLEN-1:0] imm_c;

  alu_op_decoder #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .dec_c (dec_c),
    .imm_c (imm_c)
  );

  state_e          state_q, state_d;
  logic            in_ready_q, in_ready_d;
  alu_op_e         alu_op_q, alu_op_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic            pend_wb_q, pend_wb_d, pend_br_q, pend_br_d, pend_neg_q, pend_neg_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_wb_en_q, out_wb_en_d, out_taken_q, out_taken_d, out_illegal_q, out_illegal_d;

  // Next-state and registered-output computation; ALU drive is non-NOP only in EXEC.
  always_comb begin
    state_d       = state_q;
    alu_op_d      = ALU_NOP;
    op1_d         = '0;
    op2_d         = '0;
    pend_rd_d     = pend_rd_q;
    pend_wb_d     = pend_wb_q;
    pend_br_d     = pend_br_q;
    pend_neg_d    = pend_neg_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_wb_en_d   = out_wb_en_q;
    out_taken_d   = out_taken_q;
    out_illegal_d = out_illegal_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pend_rd_d  = in_instr[11:7];
          pend_wb_d  = dec_c.wb_en;
          pend_br_d  = dec_c.is_branch;
          pend_neg_d = dec_c.br_neg;
          if (dec_c.illegal) begin
            state_d       = ST_RESP;
            out_result_d  = '0;
            out_rd_d      = in_instr[11:7];
            out_wb_en_d   = 1'b0;
            out_taken_d   = 1'b0;
            out_illegal_d = 1'b1;
          end else begin
            state_d  = ST_EXEC;
            alu_op_d = dec_c.alu_op;
            op1_d    = in_rs1_data;
            op2_d    = (dec_c.op2_sel == OP2_IMM) ? imm_c : in_rs2_data;
          end
        end
      end
      ST_EXEC: begin
        state_d       = ST_RESP;
        out_result_d  = XLEN'(alu_result);
        out_rd_d      = pend_rd_q;
        out_wb_en_d   = pend_wb_q;
        out_taken_d   = pend_br_q && (alu_zero ^ pend_neg_q);
        out_illegal_d = 1'b0;
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d       = ST_IDLE;
          out_result_d  = '0;
          out_rd_d      = '0;
          out_wb_en_d   = 1'b0;
          out_taken_d   = 1'b0;
          out_illegal_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      in_ready_q    <= 1'b1;
      alu_op_q      <= ALU_NOP;
      op1_q         <= '0;
      op2_q         <= '0;
      pend_rd_q     <= '0;
      pend_wb_q     <= 1'b0;
      pend_br_q     <= 1'b0;
      pend_neg_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_rd_q      <= '0;
      out_wb_en_q   <= 1'b0;
      out_taken_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      alu_op_q      <= alu_op_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      pend_rd_q     <= pend_rd_d;
      pend_wb_q     <= pend_wb_d;
      pend_br_q     <= pend_br_d;
      pend_neg_q    <= pend_neg_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_rd_q      <= out_rd_d;
      out_wb_en_q   <= out_wb_en_d;
      out_taken_q   <= out_taken_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign in_ready         = in_ready_q;
  assign alu_op           = alu_op_q;
  assign alu_operand1     = op1_q;
  assign alu_operand2     = op2_q;
  assign out_valid        = out_valid_q;
  assign out_result       = out_result_q;
  assign out_rd           = out_rd_q;
  assign out_wb_en        = out_wb_en_q;
  assign out_branch_taken = out_taken_q;
  assign out_illegal      = out_illegal_q;

endmodule
